// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: FETCH/DECODE/EXEC/MEM/WB.
// Optional retired-instruction counter port `instret` when MULTICYCLE_INSTRET_EN is defined.
module multicycle_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  mem_ready,
    output logic [2:0]            ImmSrc,
    output logic [DATA_WIDTH-1:0] ir_q,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  reg_we,
    output logic                  pc_load,
    output logic                  retire,
    output logic                  illegal,
    output logic                  busy
`ifdef MULTICYCLE_INSTRET_EN
   ,output logic [31:0]           instret
`endif
);

    // Immediate-format codes shared with sign_extend (same values as def.sv).
    localparam logic [2:0] SIGN_EXTEND_I  = 3'd0;
    localparam logic [2:0] SIGN_EXTEND_S  = 3'd1;
    localparam logic [2:0] SIGN_EXTEND_B  = 3'd2;
    localparam logic [2:0] SIGN_EXTEND_U  = 3'd3;
    localparam logic [2:0] SIGN_EXTEND_J  = 3'd4;
    localparam logic [2:0] SIGN_EXTEND_I5 = 3'd5;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_d;
    logic [2:0]            imm_src_q, imm_src_d;
    op_class_t             op_class;
    logic [2:0]            imm_dec;
    logic [6:0]            opcode;
    logic [2:0]            funct3;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign ImmSrc = imm_src_q;

    always_comb begin
        op_class = CLS_ILLEGAL;
        imm_dec  = SIGN_EXTEND_I;
        case (opcode)
            7'b0000011: begin op_class = CLS_LOAD;   imm_dec = SIGN_EXTEND_I; end
            7'b0100011: begin op_class = CLS_STORE;  imm_dec = SIGN_EXTEND_S; end
            7'b1100011: begin op_class = CLS_BRANCH; imm_dec = SIGN_EXTEND_B; end
            7'b0110111,
            7'b0010111: begin op_class = CLS_ALU;    imm_dec = SIGN_EXTEND_U; end
            7'b1101111: begin op_class = CLS_JUMP;   imm_dec = SIGN_EXTEND_J; end
            7'b1100111: begin op_class = CLS_JUMP;   imm_dec = SIGN_EXTEND_I; end
            7'b0010011: begin
                op_class = CLS_ALU;
                imm_dec  = (funct3 == 3'b001 || funct3 == 3'b101) ? SIGN_EXTEND_I5
                                                                  : SIGN_EXTEND_I;
            end
            7'b0110011: begin op_class = CLS_ALU;    imm_dec = SIGN_EXTEND_I; end
            default:    begin op_class = CLS_ILLEGAL; imm_dec = SIGN_EXTEND_I; end
        endcase
    end

    // All control outputs decode from state_q/ir_q; only mem_ready may act combinationally.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        imm_src_d   = imm_src_q;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        pc_load     = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (op_class == CLS_ILLEGAL) begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end else begin
                    imm_src_d = imm_dec;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                case (op_class)
                    CLS_BRANCH: begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    CLS_JUMP: begin
                        pc_load = 1'b1;
                        state_d = WB;
                    end
                    CLS_LOAD,
                    CLS_STORE: state_d = MEM;
                    default:   state_d = WB;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_class == CLS_STORE);
                if (mem_ready) begin
                    if (op_class == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign busy = (state_q != FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            imm_src_q <= SIGN_EXTEND_I;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_src_q <= imm_src_d;
        end
    end

`ifdef MULTICYCLE_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    assign instret_d = instret_q + {31'b0, retire};
    assign instret   = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver pushes expected retire/illegal events, monitor pops and compares.
// Also exercises reset values, asynchronous reset during a MEM wait and, if MULTICYCLE_INSTRET_EN, counter wrap.
module tb_multicycle_ctrl;

    localparam int unsigned DW = 32;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_B  = 3'd2;
    localparam logic [2:0] IMM_U  = 3'd3;
    localparam logic [2:0] IMM_J  = 3'd4;
    localparam logic [2:0] IMM_I5 = 3'd5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [DW-1:0] instr = '0;
    logic          mem_ready = 1'b0;
    logic [2:0]    ImmSrc;
    logic [DW-1:0] ir_q;
    logic          mem_req, mem_we, reg_we, pc_load, retire, illegal, busy;
`ifdef MULTICYCLE_INSTRET_EN
    logic [31:0]   instret;
    logic [31:0]   exp_instret = '0;
`endif

    multicycle_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .ImmSrc     (ImmSrc),
        .ir_q       (ir_q),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .pc_load    (pc_load),
        .retire     (retire),
        .illegal    (illegal),
        .busy       (busy)
`ifdef MULTICYCLE_INSTRET_EN
       ,.instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] instr;
        int unsigned acc;
        int unsigned lat;
        bit          illegal;
        int unsigned pc_cnt;
        bit          reg_we;
        int unsigned mem_cnt;
        int unsigned we_cnt;
        logic [2:0]  imm;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: observable effects of one instruction with n extra memory wait cycles.
    function automatic exp_t model(input logic [31:0] ins, input int unsigned n);
        exp_t       e;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        e.instr = ins; e.acc = 0; e.lat = 3; e.illegal = 1'b0; e.pc_cnt = 0;
        e.reg_we = 1'b0; e.mem_cnt = 0; e.we_cnt = 0; e.imm = IMM_I;
        case (op)
            7'h03: begin e.imm = IMM_I; e.lat = 4 + n; e.reg_we = 1'b1; e.mem_cnt = n + 1; end
            7'h23: begin e.imm = IMM_S; e.lat = 3 + n; e.mem_cnt = n + 1; e.we_cnt = n + 1; end
            7'h63: begin e.imm = IMM_B; e.lat = 2; e.pc_cnt = 1; end
            7'h37, 7'h17: begin e.imm = IMM_U; e.reg_we = 1'b1; end
            7'h6f: begin e.imm = IMM_J; e.pc_cnt = 1; e.reg_we = 1'b1; end
            7'h67: begin e.imm = IMM_I; e.pc_cnt = 1; e.reg_we = 1'b1; end
            7'h13: begin
                e.imm = (f3 == 3'd1 || f3 == 3'd5) ? IMM_I5 : IMM_I;
                e.reg_we = 1'b1;
            end
            7'h33: begin e.imm = IMM_I; e.reg_we = 1'b1; end
            default: begin e.illegal = 1'b1; e.lat = 1; end
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge starting the cycle after completion.
    task automatic issue(input logic [31:0] ins, input int unsigned n);
        exp_t        e;
        int unsigned guard = 0;
        int unsigned a;
        bit          is_mem;
        while (!instr_ready && guard < 50) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) begin
            check("fetch_timeout", instr_ready, 1);
            return;
        end
        instr_valid = 1'b1;
        instr       = ins;
        mem_ready   = 1'($urandom_range(0, 1));
        a           = cyc;
        e           = model(ins, n);
        e.acc       = a;
        is_mem      = !e.illegal && (e.mem_cnt != 0);
        sb_q.push_back(e);
        for (int unsigned k = 1; k <= e.lat; k++) begin
            @(negedge clk);
            instr_valid = 1'($urandom_range(0, 1));
            instr       = $urandom;
            if (is_mem && k >= 3 && k < 3 + n)
                mem_ready = 1'b0;
            else if (is_mem && k == 3 + n)
                mem_ready = 1'b1;
            else
                mem_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        instr_valid = 1'b0;
        mem_ready   = 1'($urandom_range(0, 1));
    endtask

    // Monitor: accumulate per-instruction activity, compare on each retire/illegal pulse.
    initial begin
        int unsigned pc_acc = 0, mem_acc = 0, we_acc = 0;
        bit          ready_next = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #3;
            if (!mon_en) begin
                pc_acc = 0; mem_acc = 0; we_acc = 0; ready_next = 1'b0;
                continue;
            end
            if (ready_next) check("ready_after_illegal", instr_ready, 1);
            ready_next = 1'b0;
`ifdef MULTICYCLE_INSTRET_EN
            check("instret", instret, exp_instret);
`endif
            if (pc_load) pc_acc++;
            if (mem_req) mem_acc++;
            if (mem_we)  we_acc++;
            if (reg_we && !retire) check("reg_we_without_retire", reg_we, 0);
            if (retire || illegal) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", {30'b0, retire, illegal}, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("latency",       cyc - e.acc, e.lat);
                    check("illegal",       illegal, e.illegal);
                    check("retire",        retire, !e.illegal);
                    check("reg_we",        reg_we, e.reg_we);
                    check("pc_load_cyc",   pc_acc, e.pc_cnt);
                    check("mem_req_cyc",   mem_acc, e.mem_cnt);
                    check("mem_we_cyc",    we_acc, e.we_cnt);
                    check("ir_q",          ir_q, e.instr);
                    check("busy",          busy, 1);
                    if (!e.illegal) check("ImmSrc", ImmSrc, e.imm);
                    if (e.illegal) ready_next = 1'b1;
`ifdef MULTICYCLE_INSTRET_EN
                    if (retire) exp_instret++;
`endif
                end
                pc_acc = 0; mem_acc = 0; we_acc = 0;
            end
        end
    end

    initial begin
        #500000;
        check("watchdog", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    logic [6:0] ops [0:9] = '{7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h13, 7'h33, 7'h0f};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        int unsigned idx;

        #2;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_busy",        busy, 0);
        check("rst_ir_q",        ir_q, 0);
        check("rst_ImmSrc",      ImmSrc, IMM_I);
        check("rst_outs",        {mem_req, mem_we, reg_we, pc_load, retire, illegal}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        issue(32'h00500093, 0);
        issue(32'h00112023, 3);
        issue(32'h00000463, 0);
        issue(32'h00000073, 0);

        repeat (300) begin
            idx = $urandom_range(0, 11);
            r   = $urandom;
            if (idx < 10)       op = ops[idx];
            else if (idx == 10) op = 7'h73;
            else                op = r[6:0];
            issue({r[31:7], op}, $urandom_range(0, 4));
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        // Abandon a load mid-MEM wait with an asynchronous reset.
        mon_en = 1'b0;
        instr_valid = 1'b1;
        instr       = 32'h00012083;
        mem_ready   = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("lw_in_mem_wait", mem_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_req",     mem_req, 0);
        check("rstmid_retire",      retire, 0);
        check("rstmid_reg_we",      reg_we, 0);
        check("rstmid_ir_q",        ir_q, 0);
        check("rstmid_instr_ready", instr_ready, 1);
        check("rstmid_busy",        busy, 0);
        @(negedge clk);
        #1;
        check("rstmid_hold_retire", retire, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
`ifdef MULTICYCLE_INSTRET_EN
        exp_instret = '0;
        #1;
        check("instret_after_reset", instret, 0);
        @(negedge clk);
        force dut.instret_q = 32'hFFFFFFFE;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFFFFFE;
        @(negedge clk);
        mon_en = 1'b1;
        issue(32'h00500093, 0);
        issue(32'h00500093, 0);
        @(negedge clk);
        #1;
        check("instret_wrap", instret, 32'h0);
`else
        mon_en = 1'b1;
        issue(32'h00500093, 0);
`endif
        repeat (2) @(negedge clk);
        check("final_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, instruction/data width.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  fetched instruction available.
- instr_ready  out  1  controller accepts instruction.
- instr  in  DATA_WIDTH  fetched instruction word.
- mem_ready  in  1  data memory completes the current access.
- ImmSrc  out  3  immediate format select for sign_extend; uses the SIGN_EXTEND_* codes from def.sv.
- ir_q  out  DATA_WIDTH  latched instruction register.
- mem_req  out  1  data memory request.
- mem_we  out  1  store qualifier for mem_req.
- reg_we  out  1  register file write enable.
- pc_load  out  1  load PC from branch/jump target.
- retire  out  1  one-cycle pulse on instruction completion.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- busy  out  1  state is not FETCH.

Function
REQ-003 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB.
REQ-004 FETCH: instr_ready=1; when instr_valid=1, latch instr into ir_q and go to DECODE. Otherwise stay in FETCH.
REQ-005 DECODE SHALL last one cycle and register ImmSrc from ir_q[6:0]:
- 0000011 load -> I.
- 0100011 store -> S.
- 1100011 branch -> B.
- 0110111 LUI / 0010111 AUIPC -> U.
- 1101111 JAL -> J.
- 1100111 JALR -> I.
- 0010011 OP-IMM -> I5 if funct3 is 001 or 101, else I.
- 0110011 R-type -> I (don't-care).
REQ-006 Any other opcode, including FENCE and SYSTEM: in DECODE, pulse illegal, return to FETCH, and assert no write, memory or retire signal.
REQ-007 ImmSrc SHALL stay stable from the cycle after DECODE until the next DECODE.
REQ-008 EXEC SHALL last one cycle.
- Branch: pc_load=1, retire=1, next state FETCH. pc_load is asserted regardless of outcome; the datapath selects the target.
- JAL/JALR: pc_load=1, next state WB.
- Load/store: next state MEM.
- All others: next state WB.
REQ-009 MEM: mem_req=1 held until the cycle with mem_ready=1; mem_we=1 throughout for stores, 0 for loads.
- Store completes: retire=1, next state FETCH.
- Load completes: next state WB.
- mem_ready while not in MEM SHALL be ignored.
REQ-010 WB: reg_we=1 and retire=1 for one cycle, then FETCH.
REQ-011 Latency from accept to retire: branch 2 cycles, ALU/U/J 3 cycles, store 3+N, load 4+N (N = extra MEM wait cycles).
REQ-012 mem_req, mem_we, reg_we, pc_load, retire, illegal and instr_ready SHALL be decoded from registered state only; instr_valid SHALL not combinationally affect any output.

Reset
REQ-013 rst_n=0 SHALL immediately force:
- state=FETCH, ir_q=0, ImmSrc=SIGN_EXTEND_I code.
- mem_req, mem_we, reg_we, pc_load, retire, illegal, busy = 0.
- instr_ready=1.
REQ-014 Reset asserted mid-instruction (including during MEM wait) SHALL abandon the instruction: no retire, no reg_we, mem_req drops asynchronously.

Configuration
REQ-015 With macro MULTICYCLE_INSTRET_EN defined, add output instret (out, 32, retired-instruction count):
- Increments on each retire pulse; wraps 0xFFFFFFFF->0.
- Cleared by reset.
- Not incremented by illegal.
REQ-016 Without MULTICYCLE_INSTRET_EN, the port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-017 After reset, instr_valid=1, instr=0x00500093 (addi x1,x0,5): ImmSrc=I from cycle 2 after accept; reg_we=retire=1 exactly 3 cycles after accept; back in FETCH next cycle.
REQ-018 Store instr=0x00112023 (sw) with mem_ready held low 3 cycles: mem_req=mem_we=1 for 4 cycles; retire on the mem_ready cycle; reg_we never asserted.
REQ-019 Branch instr=0x00000463 (beq): ImmSrc=B; pc_load=retire=1 in EXEC; 2 cycles accept-to-retire.
REQ-020 instr=0x00000073 (ecall): illegal pulses once in DECODE; no reg_we/mem_req/retire; instr_ready=1 the following cycle.
REQ-021 Load instr=0x00012083 (lw) with rst_n dropped during MEM wait: mem_req=0 immediately; no retire; ir_q=0; instr_ready=1.
REQ-022 With MULTICYCLE_INSTRET_EN: instret preloaded to 0xFFFFFFFE by force, two addi retired -> 0x00000000.
